// File: rtl/bus_mailbox_pkg.sv
// Shared definitions for the CPU mailbox: register offsets and bit positions
// within the STATUS and CTRL registers.
package bus_mailbox_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_PEEK   = 2'd3;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_NOT_FULL = 1;
  localparam int unsigned ST_RX_OVF      = 2;
  localparam int unsigned ST_TX_OVF      = 3;

  localparam int unsigned CTRL_FLUSH_RX = 0;
  localparam int unsigned CTRL_FLUSH_TX = 1;
  localparam int unsigned CTRL_CLR_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with combinational head, flush and occupancy count.
// Push when full and pop when empty are ignored internally.
module sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage needs no reset; entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/bus_mailbox.sv
// Memory-mapped CPU mailbox: 4-byte window with an RX FIFO drained by CPU reads
// and a TX FIFO filled by CPU writes. Side effects fire once per CPU access.
module bus_mailbox
  import bus_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h6000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] adr_bus,
  input  logic        RW,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  rx_in_data,
  input  logic        rx_in_valid,
  output logic        rx_in_ready,
  output logic [7:0]  tx_out_data,
  output logic        tx_out_valid,
  input  logic        tx_out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          w_sel, w_first, w_rd_first, w_wr_first;
  logic [1:0]    w_off;
  logic [3:0]    w_acc;
  logic [3:0]    r_prev_acc;
  logic [7:0]    r_data_out, w_rd_data, w_status;
  logic          r_rx_ovf, r_tx_ovf;
  logic [7:0]    w_rx_head;
  logic          w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic [CW-1:0] w_rx_count, w_tx_count;
  logic          w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic          w_ctrl_wr, w_flush_rx, w_flush_tx, w_clr_ovf;
  logic          w_tx_ovf_set, w_rx_ovf_set;

  assign w_sel      = (adr_bus[15:2] == BASE_ADDR[15:2]);
  assign w_off      = adr_bus[1:0];
  assign w_acc      = {w_sel, RW, w_off};
  assign w_first    = (w_acc != r_prev_acc);
  assign w_rd_first = w_sel & RW & w_first;
  assign w_wr_first = w_sel & ~RW & w_first;
  assign data_oe    = w_sel & RW;
  assign data_out   = r_data_out;

  assign w_rx_push    = rx_in_valid & ~w_rx_full;
  assign w_rx_ovf_set = rx_in_valid & w_rx_full;
  assign w_rx_pop     = w_rd_first & (w_off == OFF_DATA) & ~w_rx_empty;
  assign w_tx_push    = w_wr_first & (w_off == OFF_DATA) & ~w_tx_full;
  assign w_tx_ovf_set = w_wr_first & (w_off == OFF_DATA) & w_tx_full;
  assign w_tx_pop     = ~w_tx_empty & tx_out_ready;
  assign w_ctrl_wr    = w_wr_first & (w_off == OFF_CTRL);
  assign w_flush_rx   = w_ctrl_wr & data_in[CTRL_FLUSH_RX];
  assign w_flush_tx   = w_ctrl_wr & data_in[CTRL_FLUSH_TX];
  assign w_clr_ovf    = w_ctrl_wr & data_in[CTRL_CLR_OVF];

  assign rx_in_ready  = ~w_rx_full;
  assign tx_out_valid = ~w_tx_empty;

  always_comb begin
    w_status                 = '0;
    w_status[ST_RX_NONEMPTY] = (w_rx_count != '0);
    w_status[ST_TX_NOT_FULL] = (w_tx_count != CW'(DEPTH));
    w_status[ST_RX_OVF]      = r_rx_ovf;
    w_status[ST_TX_OVF]      = r_tx_ovf;
  end

  // Later cycles of a held RX_DATA read keep the latched byte.
  always_comb begin
    w_rd_data = r_data_out;
    unique case (w_off)
      OFF_DATA:   if (w_first) w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
      OFF_STATUS: w_rd_data = w_status;
      OFF_CTRL:   w_rd_data = 8'h00;
      OFF_PEEK:   w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_prev_acc <= '0;
      r_data_out <= 8'h00;
      r_rx_ovf   <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      r_prev_acc <= w_acc;
      if (w_sel && RW) r_data_out <= w_rd_data;
      if (w_clr_ovf) begin
        r_rx_ovf <= 1'b0;
        r_tx_ovf <= 1'b0;
      end else begin
        if (w_rx_ovf_set) r_rx_ovf <= 1'b1;
        if (w_tx_ovf_set) r_tx_ovf <= 1'b1;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .i_push  (w_rx_push),
    .i_data  (rx_in_data),
    .i_pop   (w_rx_pop),
    .i_flush (w_flush_rx),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .i_push  (w_tx_push),
    .i_data  (data_in),
    .i_pop   (w_tx_pop),
    .i_flush (w_flush_tx),
    .o_head  (tx_out_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

endmodule

// File: tb/tb_bus_mailbox.sv
// Scoreboard bench for bus_mailbox: stimulus pushes expected read data and
// expected TX bytes into queues, monitors pop and compare on DUT outputs.
module tb_bus_mailbox;

  localparam logic [15:0] BASE = 16'h6000;
  localparam logic [15:0] IDLE = 16'h0000;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] adr_bus;
  logic        RW;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  rx_in_data;
  logic        rx_in_valid;
  logic        rx_in_ready;
  logic [7:0]  tx_out_data;
  logic        tx_out_valid;
  logic        tx_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];

  bus_mailbox #(.BASE_ADDR(BASE), .DEPTH(16)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .adr_bus      (adr_bus),
    .RW           (RW),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .rx_in_data   (rx_in_data),
    .rx_in_valid  (rx_in_valid),
    .rx_in_ready  (rx_in_ready),
    .tx_out_data  (tx_out_data),
    .tx_out_valid (tx_out_valid),
    .tx_out_ready (tx_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read monitor: every posedge with data_oe yields one data_out sample.
  logic       m_oe;
  logic [7:0] m_exp;
  always @(posedge clk) begin
    m_oe = data_oe & n_reset;
    #2;
    if (m_oe) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'(data_out), 32'hFFFF_FFFF);
      else begin
        m_exp = rd_q.pop_front();
        check("rd_data", 32'(data_out), 32'(m_exp));
      end
    end
  end

  // TX consumer monitor: a handshake at the edge pops one expected byte.
  logic [7:0] t_exp;
  always @(posedge clk) begin
    if (n_reset && tx_out_valid && tx_out_ready) begin
      if (tx_q.size() == 0) check("tx_unexpected", 32'(tx_out_data), 32'hFFFF_FFFF);
      else begin
        t_exp = tx_q.pop_front();
        check("tx_data", 32'(tx_out_data), 32'(t_exp));
      end
    end
  end

  task automatic cpu_read(input logic [1:0] off, input logic [7:0] exp, input int hold);
    @(negedge clk);
    adr_bus = BASE | 16'(off);
    RW      = 1'b1;
    for (int i = 0; i < hold; i++) rd_q.push_back(exp);
    repeat (hold) @(negedge clk);
    adr_bus = IDLE;
  endtask

  task automatic cpu_write(input logic [1:0] off, input logic [7:0] d);
    @(negedge clk);
    adr_bus = BASE | 16'(off);
    RW      = 1'b0;
    data_in = d;
    @(negedge clk);
    adr_bus = IDLE;
    RW      = 1'b1;
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk);
    rx_in_valid = 1'b1;
    rx_in_data  = d;
    @(negedge clk);
    rx_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset      = 1'b1;
    adr_bus      = IDLE;
    RW           = 1'b1;
    data_in      = 8'h00;
    rx_in_data   = 8'h00;
    rx_in_valid  = 1'b0;
    tx_out_ready = 1'b0;
    #2 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_rx_ready", 32'(rx_in_ready), 32'h1);
    check("rst_tx_valid", 32'(tx_out_valid), 32'h0);
    check("rst_data_oe", 32'(data_oe), 32'h0);
    n_reset = 1'b1;

    // Basic RX path and STATUS
    rx_push(8'hA5);
    rx_push(8'h3C);
    cpu_read(2'd1, 8'h03, 1);
    cpu_read(2'd0, 8'hA5, 1);
    cpu_read(2'd0, 8'h3C, 1);
    cpu_read(2'd1, 8'h02, 1);
    cpu_read(2'd0, 8'h00, 1);
    cpu_read(2'd2, 8'h00, 1);

    // Held RX_DATA read pops exactly once
    rx_push(8'h11);
    rx_push(8'h22);
    cpu_read(2'd0, 8'h11, 3);
    cpu_read(2'd3, 8'h22, 1);
    cpu_read(2'd0, 8'h22, 1);
    cpu_read(2'd1, 8'h02, 1);

    // TX overflow and in-order drain
    for (int i = 0; i < 17; i++) cpu_write(2'd0, 8'(i));
    check("tx_valid_full", 32'(tx_out_valid), 32'h1);
    cpu_read(2'd1, 8'h08, 1);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    @(negedge clk);
    tx_out_ready = 1'b1;
    for (int i = 0; i < 40 && tx_out_valid; i++) @(negedge clk);
    tx_out_ready = 1'b0;
    check("tx_drained_valid", 32'(tx_out_valid), 32'h0);
    check("tx_drained_queue", 32'(tx_q.size()), 32'h0);

    // RX overflow, then flush RX and clear flags
    for (int i = 0; i < 16; i++) rx_push(8'h80 + 8'(i));
    check("rx_full_ready", 32'(rx_in_ready), 32'h0);
    rx_push(8'hEE);
    cpu_read(2'd1, 8'h0F, 1);
    cpu_read(2'd3, 8'h80, 1);
    cpu_write(2'd2, 8'h05);
    check("rx_flush_ready", 32'(rx_in_ready), 32'h1);
    cpu_read(2'd1, 8'h02, 1);

    // Simultaneous producer push and CPU pop on a one-entry RX
    rx_push(8'h40);
    @(negedge clk);
    adr_bus     = BASE;
    RW          = 1'b1;
    rx_in_valid = 1'b1;
    rx_in_data  = 8'h77;
    rd_q.push_back(8'h40);
    @(negedge clk);
    adr_bus     = IDLE;
    rx_in_valid = 1'b0;
    cpu_read(2'd1, 8'h03, 1);
    cpu_read(2'd3, 8'h77, 1);
    cpu_read(2'd0, 8'h77, 1);
    cpu_read(2'd1, 8'h02, 1);

    // Asynchronous reset in the middle of a held RX_DATA read
    rx_push(8'h99);
    cpu_write(2'd0, 8'h55);
    check("pre_rst_tx_valid", 32'(tx_out_valid), 32'h1);
    @(negedge clk);
    adr_bus = BASE;
    RW      = 1'b1;
    rd_q.push_back(8'h99);
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    adr_bus = IDLE;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    check("mid_rst_rx_ready", 32'(rx_in_ready), 32'h1);
    check("mid_rst_tx_valid", 32'(tx_out_valid), 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    cpu_read(2'd1, 8'h02, 1);
    cpu_read(2'd0, 8'h00, 1);

    repeat (3) @(negedge clk);
    check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    check("tx_queue_empty", 32'(tx_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
